// File: rtl/score_display_ctrl_if.sv
// Request channel of score_display_ctrl: two producers offering signed 16-bit
// scores through a valid/ready handshake.
interface score_display_ctrl_if;
    logic [1:0]  req_valid;
    logic [31:0] req_value;
    logic [1:0]  req_ready;

    modport master (output req_valid, output req_value, input req_ready);
    modport slave  (input req_valid, input req_value, output req_ready);
endinterface

// File: rtl/score_display_ctrl.sv
// Seven-segment score scheduler: round-robin accept, shift-add-3 BCD conversion, hold time.
// Optional macro DISP_LEADING_BLANK_EN blanks leading-zero digits with code 4'hB.
module score_display_ctrl #(
    parameter int unsigned HOLD_CYCLES = 10_000_000,
    parameter int unsigned HOLD_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    score_display_ctrl_if.slave  req,
    output logic                 busy,
    output logic [23:0]          digits,
    output logic                 neg,
    output logic                 disp_valid,
    output logic                 update
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    logic [1:0]        state;
    logic              last_grant;
    logic              sign;
    logic [15:0]       mag;
    logic [19:0]       bcd;
    logic [3:0]        bit_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic [1:0]  grant;
    logic [15:0] sel_value;
    logic [15:0] sel_mag;
    logic [19:0] bcd_adj;
    logic [35:0] shifted;
    logic [19:0] bcd_next;
    logic [15:0] mag_next;
    logic [23:0] disp_next;

    // Arbitration: only in IDLE, and on a tie the requester that did not win last time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant = 2'b00;
        if (!rst && state == ST_IDLE) begin
            case (req.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req.req_ready = grant;
    assign busy          = (state != ST_IDLE);

    // Two's-complement magnitude; -32768 maps to 16'h8000 read as unsigned 32768.
    assign sel_value = grant[1] ? req.req_value[31:16] : req.req_value[15:0];
    assign sel_mag   = sel_value[15] ? (~sel_value + 16'd1) : sel_value;

    // One double-dabble step: correct each nibble >= 5, then shift the whole register.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        shifted  = {bcd_adj, mag} << 1;
        bcd_next = shifted[35:16];
        mag_next = shifted[15:0];
    end

`ifdef DISP_LEADING_BLANK_EN
    logic leading;

    // Blank from the top digit down until the first nonzero; the ones digit always shows.
    always_comb begin
        disp_next = {4'h0, bcd_next};
        leading   = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            if (leading && disp_next[4*i +: 4] == 4'h0) begin
                disp_next[4*i +: 4] = 4'hB;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign disp_next = {4'h0, bcd_next};
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            sign       <= 1'b0;
            mag        <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            digits     <= '0;
            neg        <= 1'b0;
            disp_valid <= 1'b0;
            update     <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        sign       <= sel_value[15];
                        mag        <= sel_mag;
                        bcd        <= '0;
                        bit_cnt    <= '0;
                        last_grant <= grant[1];
                        state      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd     <= bcd_next;
                    mag     <= mag_next;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        digits     <= disp_next;
                        neg        <= sign & (bcd_next != 20'd0);
                        update     <= 1'b1;
                        disp_valid <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        hold_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: a cycle-level reference model predicts
// grants and pushes expected displays; a separate monitor checks every update.
module tb_score_display_ctrl;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [23:0] digits;
    logic        neg;
    logic        disp_valid;
    logic        update;

    always #5 clk = ~clk;

    score_display_ctrl_if bus ();

    score_display_ctrl #(.HOLD_CYCLES(HOLD), .HOLD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus),
        .busy       (busy),
        .digits     (digits),
        .neg        (neg),
        .disp_valid (disp_valid),
        .update     (update)
    );

    typedef struct {
        int          cycle;
        logic [23:0] digits;
        logic        neg;
    } exp_t;

    exp_t sb[$];
    int   n_vec      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   accept_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Decimal digits of a magnitude by plain division; digit i is a leading zero iff m < 10**i.
    function automatic logic [23:0] to_digits(input int m);
        logic [23:0] d;
        int          p;
        d = '0;
        p = 1;
        for (int i = 0; i < 6; i++) begin
            d[4*i +: 4] = 4'((m / p) % 10);
`ifdef DISP_LEADING_BLANK_EN
            if (i > 0 && m < p) d[4*i +: 4] = 4'hB;
`endif
            p = p * 10;
        end
        return d;
    endfunction

    // Reference model: the controller is free from free_at onward; one accept occupies 17+HOLD cycles.
    int free_at = 0;
    int last    = 1;

    always @(negedge clk) begin
        logic [1:0]         er;
        logic signed [15:0] sv;
        int                 iv;
        exp_t               e;
        if (rst) begin
            check("ready_in_reset", bus.req_ready, 2'b00);
            free_at = cyc + 1;
            last    = 1;
            sb.delete();
        end else begin
            check("busy", busy, cyc < free_at);
            er = 2'b00;
            if (cyc >= free_at) begin
                case (bus.req_valid)
                    2'b01:   er = 2'b01;
                    2'b10:   er = 2'b10;
                    2'b11:   er = (last == 1) ? 2'b01 : 2'b10;
                    default: er = 2'b00;
                endcase
            end
            check("req_ready", bus.req_ready, er);
            if (er != 2'b00) begin
                sv       = er[1] ? bus.req_value[31:16] : bus.req_value[15:0];
                iv       = sv;
                e.cycle  = cyc + 17;
                e.digits = to_digits(iv < 0 ? -iv : iv);
                e.neg    = (iv < 0);
                sb.push_back(e);
                last    = er[1] ? 1 : 0;
                free_at = cyc + 17 + HOLD;
                accept_cnt++;
            end
        end
    end

    // Monitor: pops on each update pulse, otherwise requires the display to hold still.
    logic [23:0] cur_d = '0;
    logic        cur_n = 1'b0;
    logic        cur_v = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (update) begin
            if (sb.size() == 0) begin
                check("update_without_request", update, 1'b0);
            end else begin
                e = sb.pop_front();
                check("update_cycle", cyc, e.cycle);
                check("digits", digits, e.digits);
                check("neg", neg, e.neg);
                check("disp_valid", disp_valid, 1'b1);
                cur_d = e.digits;
                cur_n = e.neg;
                cur_v = 1'b1;
            end
        end else begin
            check("digits_stable", digits, cur_d);
            check("neg_stable", neg, cur_n);
            check("disp_valid_stable", disp_valid, cur_v);
        end
        if (rst) begin
            cur_d = '0;
            cur_n = 1'b0;
            cur_v = 1'b0;
        end
    end

    task automatic wait_accepts(input int target);
        int n;
        n = 0;
        while (accept_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("accepted", accept_cnt >= target, 1'b1);
        #1;
    endtask

    task automatic send(input int r, input logic [15:0] v);
        int start;
        start = accept_cnt;
        if (r == 0) bus.req_value[15:0] = v;
        else        bus.req_value[31:16] = v;
        bus.req_valid = (r == 0) ? 2'b01 : 2'b10;
        wait_accepts(start + 1);
        bus.req_valid = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_value = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send(0, 16'sd1234);
        send(0, 16'h8000);
        send(0, 16'hFFFF);
        send(0, 16'h0000);
        send(0, -16'sd45);
        send(0, 16'sd30000);
        // Requester 1 raises valid while the previous value is converting.
        send(1, 16'sd777);

        // Both requesters held valid: alternation and re-grant after hold.
        start         = accept_cnt;
        bus.req_value = {16'sd7, 16'sd5};
        bus.req_valid = 2'b11;
        wait_accepts(start + 3);
        bus.req_valid = 2'b00;

        // Reset during the 8th conversion cycle, then an immediate new request.
        send(0, 16'sd4321);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(0, 16'sd55);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       bus.req_value[15:0] = 16'h8000;
                1:       bus.req_value[15:0] = 16'h0000;
                2:       bus.req_value[15:0] = 16'h7FFF;
                default: bus.req_value[15:0] = 16'($urandom);
            endcase
            bus.req_value[31:16] = 16'($urandom);
        end
        bus.req_valid = 2'b00;
        repeat (60) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Schedules the seven-segment score display between two score producers: the NNUE evaluation result (requester 0) and the debug/host value (requester 1).
- Accepts one signed 16-bit value at a time through a valid/ready handshake, arbitrating round-robin.
- Converts the magnitude to BCD with a sequential shift-add-3 engine, replacing wide combinational divide/modulo.
- Holds each shown value for a minimum time before the display is re-granted, and presents registered digits plus a sign flag to the digit-scanning display driver.

Parameters:
- HOLD_CYCLES, 10_000_000, minimum number of cycles a converted value stays displayed before a new request can be accepted; must be >= 1.
- HOLD_W, 24, width of the hold counter; must satisfy HOLD_CYCLES < 2**HOLD_W.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  bit i set: requester i offers a value.
- req_value  input  32  [15:0] is requester 0's signed value; [31:16] is requester 1's signed value.
- req_ready  output  2  bit i set: controller accepts from requester i this cycle.
- busy  output  1  high in CONVERT and HOLD.
- digits  output  24  six BCD digits; [3:0] is the ones digit, [23:20] is the hundred-thousands digit.
- neg  output  1  displayed value is negative.
- disp_valid  output  1  at least one conversion has completed since reset.
- update  output  1  one-cycle pulse when digits and neg change.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - digits = 0, neg = 0, disp_valid = 0, update = 0, hold counter = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - req_ready = 0 while rst is high.
- req_ready is combinational from the registered state and req_valid.
  - Nonzero only in IDLE, one-hot at most, and only on a requester that is valid.
  - Requesters must not make valid depend on ready.
  - Transfer happens on valid & ready.
- IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
  - On transfer: latch sign = value[15] and mag = |value| as 16-bit unsigned (-32768 gives 32768, no overflow), update last_grant, go to CONVERT.
- CONVERT, exactly 16 cycles:
  - Each cycle, add 3 to every BCD nibble >= 5, then shift the {bcd[19:0], mag} register left by 1.
  - After the 16th cycle, register digits = {4'h0, bcd[19:0]} and neg = sign (neg = 0 if mag == 0).
  - Assert update for one cycle, set disp_valid, go to HOLD.
- HOLD:
  - The counter runs from 0; when it reaches HOLD_CYCLES-1, clear it and go to IDLE.
  - Requests are ignored (ready low).
- Timing: a transfer in cycle T gives update high and new digits visible in cycle T+17. HOLD spans T+17 .. T+16+HOLD_CYCLES. The earliest next transfer is cycle T+17+HOLD_CYCLES.
- digits and neg change only on the update cycle (or on reset); they are stable otherwise.
- A requester dropping valid before transfer causes no transfer and no state change.
- Reset mid-CONVERT or mid-HOLD aborts immediately. The accepted value is discarded, no update pulse occurs, and outputs take reset values the next cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro DISP_LEADING_BLANK_EN.
- Defined:
  - Leading-zero digits are replaced by 4'hB (the display driver's blank code) at the time digits are registered.
  - The ones digit is never blanked, so value 0 shows as a single 0.
  - neg is unaffected.
- Undefined: digits carry raw BCD including leading zeros.

Test Plan:
1. After reset, req_valid = 01 with value 16'sd1234 → req_ready = 01 in the same cycle; 17 cycles later update = 1, digits = 24'h001234, neg = 0, disp_valid = 1.
2. Value 16'h8000 (-32768) → digits = 24'h032768, neg = 1. Value -1 → digits = 24'h000001, neg = 1. Value 0 → digits = 0, neg = 0.
3. HOLD_CYCLES = 4, both requesters held valid with values 5 and 7 from reset:
   - Requester 0 is accepted at T and requester 1 at T+21.
   - Updates occur at T+17 (digits 5) and T+38 (digits 7).
   - Requester 0 is re-accepted at T+42.
4. Requester 1 raises valid during CONVERT and HOLD → req_ready stays 00 until IDLE, then 10; digits are unchanged between updates.
5. rst pulsed in the 8th CONVERT cycle → no update, digits = 0, disp_valid = 0, busy = 0 the next cycle; a new request is accepted right after rst drops.
6. With DISP_LEADING_BLANK_EN:
   - Value 0 → digits = 24'hBBBBB0.
   - Value -45 → digits = 24'hBBBB45, neg = 1.
   - Value 30000 → digits = 24'hB30000.
